// File: rtl/debug_pkg.sv
// Shared debug-controller definitions: word arbiter state encoding and the
// MSB-first byte order used for every word sent over the UART.
package debug_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_SEND = 1'b1
   } arb_state_e;

   // Index 0 is the first byte on the wire, i.e. the most significant byte.
   function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0]     word,
                                                  input logic [BYTE_IDX_W-1:0] idx);
      return word[(BYTES_PER_WORD - 1 - int'(idx)) * BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr,
// wrapping. The pointer itself is owned by the caller.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_grant_onehot,
   output logic [ID_W-1:0]  o_grant_id,
   output logic             o_any
);

   int idx;

   always_comb begin
      o_grant_id = '0;
      o_any      = 1'b0;
      idx        = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(i_ptr) + i) % N_REQ;
         if (!o_any && i_req[ID_W'(idx)]) begin
            o_any      = 1'b1;
            o_grant_id = ID_W'(idx);
         end
      end
      o_grant_onehot = o_any ? (N_REQ'(1) << o_grant_id) : '0;
   end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Shares the UART TX FIFO write port between N_REQ word producers, granting
// round-robin per word and sending each 32-bit word as 4 bytes, MSB first.
module uart_tx_word_arbiter
   import debug_pkg::*;
#(
   parameter int NB_WORD = WORD_W,
   parameter int DBIT    = BYTE_W,
   parameter int N_REQ   = 2,
   parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*NB_WORD-1:0] i_words,
   output logic [N_REQ-1:0]         o_ack,
   output logic [N_REQ-1:0]         o_done,
   input  logic                     i_tx_full,
   output logic                     o_wr_uart,
   output logic [DBIT-1:0]          o_tx_data,
   output logic                     o_busy,
   output logic [ID_W-1:0]          o_grant_id,
   output arb_state_e               o_dbg_state
);

   localparam int                 CNT_W    = $clog2(NB_WORD / DBIT);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NB_WORD / DBIT - 1);

   arb_state_e         state;
   logic [CNT_W-1:0]   byte_cnt;
   logic [NB_WORD-1:0] word_q;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_q;
   logic [N_REQ-1:0]   ack_q;
   logic [N_REQ-1:0]   done_q;

   logic [N_REQ-1:0]   pick_onehot;
   logic [ID_W-1:0]    pick_id;
   logic               pick_any;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .i_req          (i_req),
      .i_ptr          (rr_ptr),
      .o_grant_onehot (pick_onehot),
      .o_grant_id     (pick_id),
      .o_any          (pick_any)
   );

   // Handshake: i_req is a level request, held until o_ack and sampled only in
   // IDLE; a byte transfers on o_wr_uart, which is asserted only while the
   // FIFO is not full, so a stalled byte is simply re-presented.
   assign o_wr_uart   = (state == ARB_SEND) && !i_tx_full;
   assign o_tx_data   = (state == ARB_SEND) ? byte_sel(word_q, byte_cnt) : '0;
   assign o_busy      = (state == ARB_SEND);
   assign o_grant_id  = grant_q;
   assign o_ack       = ack_q;
   assign o_done      = done_q;
   assign o_dbg_state = state;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ARB_IDLE;
         byte_cnt <= '0;
         word_q   <= '0;
         rr_ptr   <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         done_q   <= '0;
      end else begin
         ack_q  <= '0;
         done_q <= '0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  word_q   <= i_words[pick_id*NB_WORD +: NB_WORD];
                  grant_q  <= pick_id;
                  byte_cnt <= '0;
                  ack_q    <= pick_onehot;
                  state    <= ARB_SEND;
               end
            end
            ARB_SEND: begin
               if (!i_tx_full) begin
                  if (byte_cnt == LAST_CNT) begin
                     // Pointer moves past the requester just served so a held
                     // request cannot starve the others.
                     done_q   <= N_REQ'(1) << grant_q;
                     rr_ptr   <= (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                     byte_cnt <= '0;
                     state    <= ARB_IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed bench for uart_tx_word_arbiter: a 2-requester instance for the main
// scenarios and a 3-requester instance for the rotation sequence.
module tb_uart_tx_word_arbiter;
   import debug_pkg::*;

   logic clk = 1'b0;
   logic i_reset;

   always #5 clk = ~clk;

   // 2-requester instance
   logic [1:0]  req2;
   logic [63:0] words2;
   logic [1:0]  ack2, done2;
   logic        full2, wr2, busy2;
   logic [7:0]  data2;
   logic [0:0]  gid2;
   arb_state_e  st2;

   // 3-requester instance
   logic [2:0]  req3;
   logic [95:0] words3;
   logic [2:0]  ack3, done3;
   logic        full3, wr3, busy3;
   logic [7:0]  data3;
   logic [1:0]  gid3;
   arb_state_e  st3;

   uart_tx_word_arbiter #(.NB_WORD(32), .DBIT(8), .N_REQ(2)) u_dut2 (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_req       (req2),
      .i_words     (words2),
      .o_ack       (ack2),
      .o_done      (done2),
      .i_tx_full   (full2),
      .o_wr_uart   (wr2),
      .o_tx_data   (data2),
      .o_busy      (busy2),
      .o_grant_id  (gid2),
      .o_dbg_state (st2)
   );

   uart_tx_word_arbiter #(.NB_WORD(32), .DBIT(8), .N_REQ(3)) u_dut3 (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_req       (req3),
      .i_words     (words3),
      .o_ack       (ack3),
      .o_done      (done3),
      .i_tx_full   (full3),
      .o_wr_uart   (wr3),
      .o_tx_data   (data3),
      .o_busy      (busy3),
      .o_grant_id  (gid3),
      .o_dbg_state (st3)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int writes2      = 0;
   int writes3      = 0;
   int busy_cyc3    = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   logic [6:0] t3_full  = 7'b0001110;
   logic [7:0] t6_bytes[12] = '{8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08,
                                8'h09, 8'h0A, 8'h0B, 8'h0C};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance to the middle of the next cycle, apply this cycle's FIFO-full level,
   // then let combinational outputs settle before checks.
   task automatic tick(input logic full);
      @(negedge clk);
      full2 = full;
      #1;
   endtask

   initial begin
      i_reset = 1'b1;
      req2 = '0; words2 = '0; full2 = 1'b0;
      req3 = '0; words3 = '0; full3 = 1'b0;
      repeat (2) tick(1'b0);

      // Reset state
      chk("rst_ack",   ack2,  2'b00);
      chk("rst_done",  done2, 2'b00);
      chk("rst_wr",    wr2,   1'b0);
      chk("rst_data",  data2, 8'h00);
      chk("rst_busy",  busy2, 1'b0);
      chk("rst_gid",   gid2,  1'b0);
      chk("rst_state", st2,   ARB_IDLE);
      chk("rst_busy3", busy3, 1'b0);
      i_reset = 1'b0;

      // Test 1: single word, MSB first
      req2   = 2'b01;
      words2 = {32'h0000_0000, 32'hDEAD_BEEF};
      tick(1'b0);
      chk("t1_ack",   ack2,  2'b01);
      chk("t1_b0",    data2, 8'hDE);
      chk("t1_wr",    wr2,   1'b1);
      chk("t1_busy",  busy2, 1'b1);
      chk("t1_state", st2,   ARB_SEND);
      req2 = 2'b00;
      tick(1'b0);
      chk("t1_b1",    data2, 8'hAD);
      chk("t1_ack_1", ack2,  2'b00);
      tick(1'b0);
      chk("t1_b2",    data2, 8'hBE);
      tick(1'b0);
      chk("t1_b3",    data2, 8'hEF);
      chk("t1_done_early", done2, 2'b00);
      tick(1'b0);
      chk("t1_done",  done2, 2'b01);
      chk("t1_idle",  busy2, 1'b0);
      chk("t1_gid",   gid2,  1'b0);
      chk("t1_wr_idle", wr2, 1'b0);
      tick(1'b0);
      chk("t1_done_pulse", done2, 2'b00);

      // Test 2: both held from a fresh pointer, alternating grants
      i_reset = 1'b1;
      tick(1'b0);
      i_reset = 1'b0;
      req2   = 2'b11;
      words2 = {32'h2222_2222, 32'h1111_1111};
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 4; b++) begin
            tick(1'b0);
            chk("t2_data", data2, (w % 2) ? 8'h22 : 8'h11);
            chk("t2_gid",  gid2,  w % 2);
            chk("t2_wr",   wr2,   1'b1);
            chk("t2_ack",  ack2,  (b == 0) ? ((w % 2) ? 2'b10 : 2'b01) : 2'b00);
         end
         tick(1'b0);
         chk("t2_done", done2, (w % 2) ? 2'b10 : 2'b01);
         chk("t2_busy", busy2, 1'b0);
         if (w == 3) req2 = 2'b00;
      end
      tick(1'b0);
      chk("t2_stays_idle", busy2, 1'b0);

      // Test 3: FIFO full stalls the 2nd byte for 3 cycles
      req2   = 2'b01;
      words2 = {32'h0000_0000, 32'hCAFE_F00D};
      exp_q.push_back(8'hCA);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h0D);
      writes2 = 0;
      for (int c = 0; c < 7; c++) begin
         tick(t3_full[c]);
         if (c == 0) req2 = 2'b00;
         chk("t3_busy", busy2, 1'b1);
         chk("t3_wr",   wr2,   !t3_full[c]);
         if (wr2) writes2++;
         if (t3_full[c]) begin
            chk("t3_hold", data2, 8'hFE);
         end else begin
            exp_b = exp_q.pop_front();
            chk("t3_data", data2, exp_b);
         end
      end
      tick(1'b0);
      chk("t3_done",   done2,   2'b01);
      chk("t3_writes", writes2, 4);

      // Test 4: reset in the middle of a word
      req2   = 2'b10;
      words2 = {32'h1234_5678, 32'hA1A2_A3A4};
      tick(1'b0);
      chk("t4_gid1", gid2,  1'b1);
      chk("t4_ack1", ack2,  2'b10);
      chk("t4_b0",   data2, 8'h12);
      req2 = 2'b00;
      tick(1'b0);
      chk("t4_b1",   data2, 8'h34);
      tick(1'b0);
      chk("t4_b2",   data2, 8'h56);
      i_reset = 1'b1;
      tick(1'b0);
      chk("t4_r_ack",  ack2,  2'b00);
      chk("t4_r_done", done2, 2'b00);
      chk("t4_r_wr",   wr2,   1'b0);
      chk("t4_r_data", data2, 8'h00);
      chk("t4_r_busy", busy2, 1'b0);
      chk("t4_r_gid",  gid2,  1'b0);
      i_reset = 1'b0;
      tick(1'b0);
      chk("t4_no_done", done2, 2'b00);
      chk("t4_idle",    busy2, 1'b0);
      req2 = 2'b11;
      tick(1'b0);
      chk("t4_gid0", gid2,  1'b0);
      chk("t4_ack0", ack2,  2'b01);
      chk("t4_a1",   data2, 8'hA1);
      req2 = 2'b00;
      tick(1'b0);
      chk("t4_a2",   data2, 8'hA2);
      tick(1'b0);
      chk("t4_a3",   data2, 8'hA3);
      tick(1'b0);
      chk("t4_a4",   data2, 8'hA4);
      tick(1'b0);
      chk("t4_done", done2, 2'b01);

      // Test 5: short req1 pulse while serving req0 is lost
      req2   = 2'b01;
      words2 = {32'h0000_0000, 32'h55AA_33CC};
      tick(1'b0);
      chk("t5_ack", ack2,  2'b01);
      chk("t5_b0",  data2, 8'h55);
      req2 = 2'b00;
      tick(1'b0);
      chk("t5_b1",  data2, 8'hAA);
      req2 = 2'b10;
      tick(1'b0);
      chk("t5_b2",  data2, 8'h33);
      chk("t5_noack_a", ack2, 2'b00);
      req2 = 2'b00;
      tick(1'b0);
      chk("t5_b3",  data2, 8'hCC);
      chk("t5_noack_b", ack2, 2'b00);
      tick(1'b0);
      chk("t5_done", done2, 2'b01);
      chk("t5_busy_drop", busy2, 1'b0);
      tick(1'b0);
      chk("t5_no_regrant", busy2, 1'b0);
      chk("t5_noack_c",    ack2,  2'b00);
      chk("t5_no_wr",      wr2,   1'b0);

      // Test 6: three requesters held for six words
      req3   = 3'b111;
      words3 = {32'h090A_0B0C, 32'h0506_0708, 32'h0102_0304};
      writes3   = 0;
      busy_cyc3 = 0;
      for (int w = 0; w < 6; w++) begin
         for (int b = 0; b < 4; b++) begin
            tick(1'b0);
            if (wr3) writes3++;
            if (busy3) busy_cyc3++;
            chk("t6_gid",  gid3,  w % 3);
            chk("t6_data", data3, t6_bytes[(w % 3) * 4 + b]);
         end
         tick(1'b0);
         if (busy3) busy_cyc3++;
         chk("t6_done", done3, 3'b001 << (w % 3));
         if (w == 5) req3 = 3'b000;
      end
      tick(1'b0);
      chk("t6_writes",   writes3,   24);
      chk("t6_busy_cyc", busy_cyc3, 24);
      chk("t6_idle",     busy3,     1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
